// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memop field layout, access sizes
// and controller states.
package lsu_pkg;

  localparam int unsigned MOP_WRITE  = 3;
  localparam int unsigned MOP_UNS    = 2;
  localparam int unsigned MOP_SZ_MSB = 1;
  localparam int unsigned MOP_SZ_LSB = 0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Data memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Sub-word lane handling: byte enables, replicated store data, extended load
// data and alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  lsb,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [31:0] sh;

  // Addressed lane moved down to bit 0 before extension.
  assign sh = rdata >> {lsb, 3'b000};

  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    ldata     = '0;
    misalign  = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lsb;
        wdata_rep = {4{wdata[7:0]}};
        ldata     = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      SZ_HALF: begin
        misalign  = lsb[0];
        be        = 4'b0011 << lsb;
        wdata_rep = {2{wdata[15:0]}};
        ldata     = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      SZ_WORD: begin
        misalign = |lsb;
        be       = '1;
        ldata    = rdata;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: request FSM, bus wait timeout and registered
// core/bus outputs.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               memop,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     misalign,
  output logic                     buserr,
  load_store_unit_if.master        bus
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_e      state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]  op_q, op_n;
  logic [1:0]  lsb_q, lsb_n;

  logic [31:0] rdata_n, addr_n, wd_n;
  logic        busy_n, done_n, mis_n, berr_n, req_n, we_n;
  logic [3:0]  be_n;

  size_e       a_size;
  logic        a_uns;
  logic [1:0]  a_lsb;
  logic [3:0]  a_be;
  logic [31:0] a_wd, a_ld;
  logic        a_mis;

  // The aligner sees the live request while idle and the latched one afterwards.
  assign a_size  = size_e'((state == S_IDLE) ? memop[MOP_SZ_MSB:MOP_SZ_LSB]
                                             : op_q[MOP_SZ_MSB:MOP_SZ_LSB]);
  assign a_uns   = (state == S_IDLE) ? memop[MOP_UNS] : op_q[MOP_UNS];
  assign a_lsb   = (state == S_IDLE) ? addr[1:0] : lsb_q;
  assign cnt_inc = cnt + 1'b1;

  lsu_align u_align (
    .size      (a_size),
    .uns       (a_uns),
    .lsb       (a_lsb),
    .wdata     (wdata),
    .rdata     (bus.mem_rdata),
    .be        (a_be),
    .wdata_rep (a_wd),
    .ldata     (a_ld),
    .misalign  (a_mis)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    lsb_n   = lsb_q;
    rdata_n = rdata;
    busy_n  = busy;
    done_n  = 1'b0;
    mis_n   = misalign;
    berr_n  = buserr;
    req_n   = bus.mem_req;
    we_n    = bus.mem_we;
    addr_n  = bus.mem_addr;
    be_n    = bus.mem_be;
    wd_n    = bus.mem_wdata;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (a_mis) begin
            state_n = S_RESP;
            done_n  = 1'b1;
            rdata_n = '0;
            mis_n   = 1'b1;
            berr_n  = 1'b0;
          end else begin
            state_n = S_ACCESS;
            cnt_n   = '0;
            op_n    = memop;
            lsb_n   = addr[1:0];
            busy_n  = 1'b1;
            req_n   = 1'b1;
            we_n    = memop[MOP_WRITE];
            addr_n  = {addr[31:2], 2'b00};
            be_n    = a_be;
            wd_n    = a_wd;
          end
        end
      end
      S_ACCESS: begin
        if (bus.mem_ack) begin
          state_n = S_RESP;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          req_n   = 1'b0;
          rdata_n = op_q[MOP_WRITE] ? '0 : a_ld;
          mis_n   = 1'b0;
          berr_n  = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_inc == TMO)) begin
          state_n = S_RESP;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          req_n   = 1'b0;
          rdata_n = '0;
          mis_n   = 1'b0;
          berr_n  = 1'b1;
        end else if (cnt != '1) begin
          cnt_n = cnt_inc;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      op_q          <= '0;
      lsb_q         <= '0;
      rdata         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      misalign      <= 1'b0;
      buserr        <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      op_q          <= op_n;
      lsb_q         <= lsb_n;
      rdata         <= rdata_n;
      busy          <= busy_n;
      done          <= done_n;
      misalign      <= mis_n;
      buserr        <= berr_n;
      bus.mem_req   <= req_n;
      bus.mem_we    <= we_n;
      bus.mem_addr  <= addr_n;
      bus.mem_be    <= be_n;
      bus.mem_wdata <= wd_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed operations, a lane-level reference model
// compared every cycle, and hand-computed spot values.
module tb_load_store_unit;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  memop = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, misalign, buserr;
  bit          run = 1'b0;

  int checks = 0;
  int fails  = 0;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .memop    (memop),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .misalign (misalign),
    .buserr   (buserr),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned nbytes(input logic [3:0] op);
    return 32'd1 << op[1:0];
  endfunction

  function automatic bit is_mis(input logic [3:0] op, input logic [31:0] a);
    if (op[1:0] == 2'b11) return 1'b1;
    return (a % nbytes(op)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] a);
    logic [3:0] be = '0;
    int unsigned off = 32'(a[1:0]);
    for (int unsigned i = 0; i < 4; i++)
      if (i >= off && i < off + nbytes(op)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [3:0] op, input logic [31:0] w);
    logic [31:0] r = '0;
    for (int unsigned i = 0; i < 4; i++)
      r[8*i +: 8] = w[8*(i % nbytes(op)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned nb  = nbytes(op);
    int unsigned off = 32'(a[1:0]);
    logic [31:0] mask, v;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
    v = (rd >> (8*off)) & mask;
    if (!op[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  logic        m_req = 0, m_done = 0, m_mis = 0, m_berr = 0, m_we = 0, m_zero = 1;
  logic [31:0] m_rdata = 0, m_addr = 0, m_wd = 0, m_a = 0;
  logic [3:0]  m_be = 0, m_op = 0;
  int unsigned m_wait = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_req <= 0; m_done <= 0; m_mis <= 0; m_berr <= 0; m_rdata <= 0;
      m_we <= 0; m_addr <= 0; m_be <= 0; m_wd <= 0; m_wait <= 0; m_zero <= 1;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_req) begin
      if (bus_if.mem_ack) begin
        m_req <= 0; m_done <= 1; m_mis <= 0; m_berr <= 0;
        m_rdata <= m_op[3] ? 32'd0 : exp_ld(m_op, m_a, bus_if.mem_rdata);
      end else begin
        m_wait <= m_wait + 1;
        if (m_wait + 1 == TMO) begin
          m_req <= 0; m_done <= 1; m_berr <= 1; m_mis <= 0; m_rdata <= 0;
        end
      end
    end else if (start) begin
      if (is_mis(memop, addr)) begin
        m_done <= 1; m_mis <= 1; m_berr <= 0; m_rdata <= 0;
      end else begin
        m_req <= 1; m_wait <= 0; m_op <= memop; m_a <= addr; m_zero <= 0;
        m_we <= memop[3]; m_addr <= addr & 32'hFFFF_FFFC;
        m_be <= exp_be(memop, addr); m_wd <= exp_wd(memop, wdata);
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("busy",     32'(busy),     32'(m_req));
      check("done",     32'(done),     32'(m_done));
      check("misalign", 32'(misalign), 32'(m_mis));
      check("buserr",   32'(buserr),   32'(m_berr));
      check("rdata",    rdata,         m_rdata);
      check("mem_req",  32'(bus_if.mem_req), 32'(m_req));
      if (m_req || m_zero) begin
        check("mem_we",    32'(bus_if.mem_we), 32'(m_we));
        check("mem_addr",  bus_if.mem_addr,    m_addr);
        check("mem_be",    32'(bus_if.mem_be), 32'(m_be));
        check("mem_wdata", bus_if.mem_wdata,   m_wd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
    start = 1'b1; memop = op; addr = a; wdata = w;
    tick();
    start = 1'b0;
  endtask

  // Ack in the n-th cycle of the request (n=1: first cycle).
  task automatic serve(input int n, input logic [31:0] rd);
    repeat (n - 1) tick();
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = rd;
    tick();
    bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'h5A5A_5A5A;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nreq;
    bit  got;
    bus_if.mem_ack = 1'b0;
    bus_if.mem_rdata = '0;
    reset = 1'b0;
    tick(); tick();
    run = 1'b1;
    check("rst_busy",  32'(busy), 0);
    check("rst_rdata", rdata, 0);
    check("rst_be",    32'(bus_if.mem_be), 0);
    reset = 1'b1;
    tick();

    // LW, ack in the third request cycle -> done 4 cycles after start
    issue(4'b0010, 32'h1001_0004, 32'h0);
    check("lw_req",  32'(bus_if.mem_req), 1);
    check("lw_addr", bus_if.mem_addr, 32'h1001_0004);
    check("lw_be",   32'(bus_if.mem_be), 32'hF);
    serve(3, 32'hDEAD_BEEF);
    check("lw_done",  32'(done), 1);
    check("lw_rdata", rdata, 32'hDEAD_BEEF);
    check("lw_busy",  32'(busy), 0);
    tick();

    // LB / LBU on lane 3
    issue(4'b0000, 32'h1001_0003, 32'h0);
    check("lb_be", 32'(bus_if.mem_be), 32'h8);
    serve(1, 32'h80FF_7F01);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    tick();
    issue(4'b0100, 32'h1001_0003, 32'h0);
    serve(2, 32'h80FF_7F01);
    check("lbu_rdata", rdata, 32'h0000_0080);
    tick();

    // LH upper half (signed), LHU lower half, LB lane 1
    issue(4'b0001, 32'h1001_0002, 32'h0); serve(1, 32'h80FF_7F01);
    check("lh_rdata", rdata, 32'hFFFF_80FF);
    tick();
    issue(4'b0101, 32'h1001_0000, 32'h0); serve(1, 32'h80FF_7F01); tick();
    issue(4'b0000, 32'h1001_0001, 32'h0); serve(2, 32'h80FF_7F01); tick();

    // SH at offset 2, SB at offset 1, SW
    issue(4'b1001, 32'h1001_0002, 32'h1234_ABCD);
    check("sh_we", 32'(bus_if.mem_we), 1);
    check("sh_be", 32'(bus_if.mem_be), 32'hC);
    check("sh_wd", bus_if.mem_wdata, 32'hABCD_ABCD);
    serve(1, 32'hFFFF_FFFF);
    check("sh_done",  32'(done), 1);
    check("sh_rdata", rdata, 32'h0);
    tick();
    issue(4'b1100, 32'h2000_0001, 32'h0000_00EF); serve(2, 32'h1111_1111); tick();
    issue(4'b1010, 32'h2000_0008, 32'hCAFE_F00D); serve(1, 32'h0); tick();

    // Misaligned: LW at +2, LH at +1, illegal size
    issue(4'b0010, 32'h1001_0002, 32'h0);
    check("mis_done", 32'(done), 1);
    check("mis_flag", 32'(misalign), 1);
    check("mis_req",  32'(bus_if.mem_req), 0);
    tick();
    check("mis_hold", 32'(misalign), 1);
    issue(4'b0001, 32'h1001_0001, 32'h0); tick();
    issue(4'b1011, 32'h1001_0000, 32'h0); tick();

    // Timeout: no ack, request high exactly TMO cycles
    issue(4'b0010, 32'h3000_0000, 32'h0);
    nreq = 0; got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (bus_if.mem_req) nreq++;
      if (done) got = 1;
      else tick();
    end
    check("to_reached", 32'(got), 1);
    check("to_reqcyc",  32'(nreq), 32'(TMO));
    check("to_buserr",  32'(buserr), 1);
    check("to_rdata",   rdata, 0);
    tick();

    // Ack in the same cycle the counter would expire
    issue(4'b0010, 32'h3000_0004, 32'h0);
    serve(TMO, 32'h1122_3344);
    check("ack4_buserr", 32'(buserr), 0);
    check("ack4_rdata",  rdata, 32'h1122_3344);
    tick();

    // Stray ack while idle
    bus_if.mem_ack = 1'b1; tick(); bus_if.mem_ack = 1'b0; tick();

    // Reset in the middle of a request
    issue(4'b0010, 32'h4000_0000, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_req",  32'(bus_if.mem_req), 0);
    check("mrst_addr", bus_if.mem_addr, 0);
    check("mrst_done", 32'(done), 0);
    tick();
    check("mrst_nodone", 32'(done), 0);

    // LW with a second start while busy; second start must be ignored
    issue(4'b0010, 32'h4000_0010, 32'h0);
    start = 1'b1; memop = 4'b1000; addr = 32'h5000_0003;
    tick();
    start = 1'b0;
    check("ign_addr", bus_if.mem_addr, 32'h4000_0010);
    serve(1, 32'h0BAD_F00D);
    check("ign_rdata", rdata, 32'h0BAD_F00D);
    tick(); tick();
    check("ign_idle", 32'(bus_if.mem_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core datapath's ALU address and write-data outputs and a variable-latency data memory bus. It accepts one memory operation per request and handles sub-word operations:
- generates byte enables and replicated write data;
- sign- or zero-extends load data;
- rejects misaligned accesses;
- aborts requests the memory never acknowledges.

It stalls the core with `busy` and returns the aligned load result as the core's `readdata`.

## Interface
- `TIMEOUT`, default 255: cycles with `mem_req` high and no `mem_ack` before abort. 0 disables the timeout.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low. `reset==0` at a rising edge clears all state.
- `start` in 1: request strobe from the core, sampled only in IDLE.
- `memop` in 4: `{write, unsigned, size[1:0]}`. Size 00 = byte, 01 = half, 10 = word, 11 = illegal. `unsigned` is ignored for stores and for word size.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rt register).
- `rdata` out 32: extended load result; 0 for stores and errors.
- `busy` out 1: operation outstanding; the core must stall.
- `done` out 1: one-cycle completion pulse.
- `misalign` out 1: valid with `done`; access rejected before reaching the bus.
- `buserr` out 1: valid with `done`; timeout abort.
- `mem_req` out 1: bus request, held until acknowledged or aborted.
- `mem_we` out 1: write access.
- `mem_addr` out 32: word address, `{addr[31:2], 2'b00}`.
- `mem_be` out 4: byte enables, little-endian (lane n = bits 8n+7:8n).
- `mem_wdata` out 32: replicated store data.
- `mem_ack` in 1: memory completion, one cycle, with `mem_rdata`.
- `mem_rdata` in 32: read word.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE, `start` high, aligned request:**
  - latch `memop` and `addr[1:0]`;
  - drive `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`;
  - go to ACCESS.
- **IDLE, `start` high, misaligned request:** go to RESP with `misalign=1` and no bus activity. Misaligned means half with `addr[0]=1`, word with `addr[1:0]≠0`, or size 11.
- **ACCESS:**
  - `mem_req=1`; bus outputs stable.
  - `mem_ack` → capture `mem_rdata`, go to RESP.
  - Otherwise increment the wait counter. When it reaches `TIMEOUT`, go to RESP with `buserr=1`.
  - `mem_ack` in the same cycle as the timeout: ack wins, no `buserr`.
- **RESP:** `done=1` for exactly one cycle, then IDLE.
- **Byte enables:**
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<addr[1:0]`
  - word: `4'b1111`
  - Driven for loads as well.
- **Store data:**
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- **Load data:** select the lane(s) by `addr[1:0]`, then sign-extend (`unsigned=0`) or zero-extend (`unsigned=1`).
- `rdata`, `misalign`, `buserr` update only on entry to RESP and hold until the next RESP. `rdata=0` when the op is a store or an error.
- `start` while not IDLE is ignored; there is no queueing.
- `mem_ack` outside ACCESS is ignored.
- **Reset, including mid-operation:** state returns to IDLE with no `done`. All outputs are 0: `rdata`, `busy`, `done`, `misalign`, `buserr`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`. The wait counter is cleared.

## Timing
- All outputs are registered.
- `start` sampled at edge E0:
  - `busy=1` and `mem_req=1` from E0 until the edge after ack.
  - ack sampled at edge Ek → `done=1`, `busy=0`, `mem_req=0` in the cycle after Ek.
- Minimum latency is 2 cycles (ack in the first request cycle).
- Misaligned requests: `done` one cycle after `start`; `mem_req` never rises.
- Timeout with `TIMEOUT=N`: `mem_req` high for exactly N cycles, then RESP.
- A new `start` is accepted in the RESP cycle's following IDLE cycle. Back-to-back throughput is one op per 3 cycles at minimum latency.
- The wait counter is `$clog2(TIMEOUT+1)` bits, saturating, and cleared on ACCESS entry.

## Structure
- Package `lsu_pkg`: `memop` field positions; size codes `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`; state encodings `S_IDLE`/`S_ACCESS`/`S_RESP`.
- Sub-module `lsu_align`, combinational: from `size`/`unsigned`/`addr[1:0]`/`wdata`/`mem_rdata`, produces `mem_be`, `mem_wdata`, the extended load value and `misalign`.
- Top level holds the FSM, wait counter and output registers.

## Test plan
- **LW:** `addr=0x10010004`, ack 3 cycles after `mem_req`, `mem_rdata=0xDEADBEEF`.
  - Required: `mem_addr=0x10010004`, `mem_be=1111`.
  - `done` 4 cycles after `start` with `rdata=0xDEADBEEF`.
- **LB / LBU:** `addr=...03`, `mem_rdata=0x80FF7F01`.
  - LB: `mem_be=1000`, `rdata=0xFFFFFF80`.
  - LBU: `rdata=0x00000080`.
- **SH:** `addr=...02`, `wdata=0x1234ABCD`.
  - Required: `mem_we=1`, `mem_be=1100`, `mem_wdata=0xABCDABCD`; `done` with `rdata=0`.
- **Misaligned LW:** `addr=...02`.
  - Required: `done`+`misalign` the next cycle; `mem_req` stays 0 throughout.
- **Timeout:** `TIMEOUT=4`, `mem_ack` never asserted.
  - Required: `mem_req` high exactly 4 cycles, then `done`+`buserr`, `rdata=0`.
  - Repeat with `mem_ack` on the 4th cycle: normal completion, `buserr=0`.
- **Reset mid-ACCESS:** `reset=0` for one edge.
  - Required: all outputs 0 next cycle, no `done`; a following LW completes normally.
  - `start` during `busy` is ignored (no second bus request).
